// File: rtl/mult_pkg.sv
// Shared encodings and helpers for the iterative multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    MUL_LO  = 2'b00,
    MULH_SS = 2'b01,
    MULH_SU = 2'b10,
    MULH_UU = 2'b11
  } op_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  // Ceiling log2, used for elaboration-time counter widths.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/mult_step.sv
// One shift-add iteration: acc + (mcand << shift) * slice.
module mult_step #(
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned SH_W           = 7
) (
  input  logic [2*DATA_W-1:0]       acc_i,
  input  logic [DATA_W-1:0]         mcand_i,
  input  logic [BITS_PER_CYCLE-1:0] slice_i,
  input  logic [SH_W-1:0]           shift_i,
  output logic [2*DATA_W-1:0]       acc_o
);
  localparam int unsigned AW = 2 * DATA_W;

  logic [AW-1:0] partial;

  always_comb begin
    partial = AW'(mcand_i) * AW'(slice_i);
    acc_o   = acc_i + (partial << shift_i);
  end

endmodule

// File: rtl/iter_mult_unit.sv
// Multi-cycle RV64M multiplier (MUL/MULH/MULHSU/MULHU) for the EX stage.
module iter_mult_unit
  import mult_pkg::*;
#(
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned TAG_W          = 5
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              enable,
  input  logic              flush,
  input  logic              start,
  input  logic [1:0]        op_mode,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              busy,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [TAG_W-1:0]  tag_out
);
  localparam int unsigned N     = DATA_W / BITS_PER_CYCLE;
  localparam int unsigned AW    = 2 * DATA_W;
  localparam int unsigned CNT_W = clog2(N + 1);
  localparam int unsigned SH_W  = clog2(AW);

  state_e             state_q,  state_d;
  op_mode_e           mode_q,   mode_d;
  logic [TAG_W-1:0]   tag_q,    tag_d;
  logic [DATA_W-1:0]  mcand_q,  mcand_d;
  logic [DATA_W-1:0]  mplier_q, mplier_d;
  logic               neg_q,    neg_d;
  logic [AW-1:0]      acc_q,    acc_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic [SH_W-1:0]    shift_q,  shift_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               done_q,   done_d;
  logic               busy_q,   busy_d;

  logic [AW-1:0]      step_acc;
  logic [AW-1:0]      product;
  op_mode_e           req_mode;
  logic               a_neg;
  logic               b_neg;

  mult_step #(
    .DATA_W         (DATA_W),
    .BITS_PER_CYCLE (BITS_PER_CYCLE),
    .SH_W           (SH_W)
  ) u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .slice_i (mplier_q[BITS_PER_CYCLE-1:0]),
    .shift_i (shift_q),
    .acc_o   (step_acc)
  );

  // Next-state: accept in IDLE/DONE, iterate in BUSY, flush overrides all.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    tag_d    = tag_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    count_d  = count_q;
    shift_d  = shift_q;
    result_d = result_q;
    done_d   = 1'b0;
    product  = '0;
    req_mode = op_mode_e'(op_mode);
    a_neg    = (req_mode == MULH_SS || req_mode == MULH_SU) && op_a[DATA_W-1];
    b_neg    = (req_mode == MULH_SS) && op_b[DATA_W-1];

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (state_q == DONE) state_d = IDLE;
          if (start) begin
            mode_d   = req_mode;
            tag_d    = tag_in;
            mcand_d  = a_neg ? (-op_a) : op_a;
            mplier_d = b_neg ? (-op_b) : op_b;
            neg_d    = a_neg ^ b_neg;
            acc_d    = '0;
            count_d  = '0;
            shift_d  = '0;
            // A zero operand needs no iterations.
            if (op_a == '0 || op_b == '0) begin
              state_d  = DONE;
              result_d = '0;
              done_d   = 1'b1;
            end else begin
              state_d = BUSY;
            end
          end
        end
        BUSY: begin
          acc_d    = step_acc;
          mplier_d = mplier_q >> BITS_PER_CYCLE;
          count_d  = count_q + CNT_W'(1);
          shift_d  = shift_q + SH_W'(BITS_PER_CYCLE);
          if (count_q == CNT_W'(N - 1)) begin
            product  = neg_q ? (-step_acc) : step_acc;
            result_d = (mode_q == MUL_LO) ? product[DATA_W-1:0] : product[AW-1:DATA_W];
            state_d  = DONE;
            done_d   = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == BUSY);
  end

  // Flush must act even while the unit is frozen by enable.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q  <= IDLE;
      mode_q   <= MUL_LO;
      tag_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      count_q  <= '0;
      shift_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else if (flush || enable) begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      tag_q    <= tag_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      shift_q  <= shift_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign tag_out = tag_q;
  assign stall   = busy_q | (start & ~busy_q);

endmodule

// File: tb/tb_iter_mult_unit.sv
// Directed bench for iter_mult_unit in 64/1, 8/1 and 64/4 configurations.
module tb_iter_mult_unit;

  logic clk = 1'b0;
  logic arst_n, enable, flush;

  logic        a_start, a_busy, a_stall, a_done;
  logic [1:0]  a_mode;
  logic [63:0] a_opa, a_opb, a_res;
  logic [4:0]  a_tag, a_tago;

  logic        b_start, b_busy, b_stall, b_done;
  logic [1:0]  b_mode;
  logic [7:0]  b_opa, b_opb, b_res;
  logic [4:0]  b_tag, b_tago;

  logic        c_start, c_busy, c_stall, c_done;
  logic [1:0]  c_mode;
  logic [63:0] c_opa, c_opb, c_res;
  logic [4:0]  c_tag, c_tago;

  int total = 0;
  int bad   = 0;
  int a_stall_low;
  int lat;
  int n;

  always #5 clk = ~clk;

  iter_mult_unit #(.DATA_W(64), .BITS_PER_CYCLE(1), .TAG_W(5)) u_a (
    .clk(clk), .arst_n(arst_n), .enable(enable), .flush(flush), .start(a_start),
    .op_mode(a_mode), .op_a(a_opa), .op_b(a_opb), .tag_in(a_tag),
    .busy(a_busy), .stall(a_stall), .done(a_done), .result(a_res), .tag_out(a_tago));

  iter_mult_unit #(.DATA_W(8), .BITS_PER_CYCLE(1), .TAG_W(5)) u_b (
    .clk(clk), .arst_n(arst_n), .enable(enable), .flush(flush), .start(b_start),
    .op_mode(b_mode), .op_a(b_opa), .op_b(b_opb), .tag_in(b_tag),
    .busy(b_busy), .stall(b_stall), .done(b_done), .result(b_res), .tag_out(b_tago));

  iter_mult_unit #(.DATA_W(64), .BITS_PER_CYCLE(4), .TAG_W(5)) u_c (
    .clk(clk), .arst_n(arst_n), .enable(enable), .flush(flush), .start(c_start),
    .op_mode(c_mode), .op_a(c_opa), .op_b(c_opb), .tag_in(c_tag),
    .busy(c_busy), .stall(c_stall), .done(c_done), .result(c_res), .tag_out(c_tago));

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic a_go(input logic [1:0] m, input logic [63:0] x, input logic [63:0] y,
                      input logic [4:0] t);
    a_mode = m; a_opa = x; a_opb = y; a_tag = t; a_start = 1'b1;
  endtask

  // Tick until done (bounded); lat counts cycles after the accept cycle.
  task automatic a_wait(input bit hold, input int lat0, output int l);
    l = lat0;
    a_stall_low = 0;
    do begin
      tick();
      l++;
      if (!hold) a_start = 1'b0;
      if (!a_done && !a_stall) a_stall_low++;
    end while (!a_done && l < lat0 + 300);
  endtask

  task automatic b_op(input logic [1:0] m, input logic [7:0] x, input logic [7:0] y,
                      output int l);
    b_mode = m; b_opa = x; b_opb = y; b_start = 1'b1;
    l = 0;
    do begin
      tick();
      l++;
      b_start = 1'b0;
    end while (!b_done && l < 100);
  endtask

  task automatic c_op(input logic [1:0] m, input logic [63:0] x, input logic [63:0] y,
                      input logic [4:0] t, output int l);
    c_mode = m; c_opa = x; c_opb = y; c_tag = t; c_start = 1'b1;
    l = 0;
    do begin
      tick();
      l++;
      c_start = 1'b0;
    end while (!c_done && l < 100);
  endtask

  initial begin
    arst_n = 1'b0; enable = 1'b1; flush = 1'b0;
    a_start = 1'b0; a_mode = 2'b00; a_opa = '0; a_opb = '0; a_tag = '0;
    b_start = 1'b0; b_mode = 2'b00; b_opa = '0; b_opb = '0; b_tag = '0;
    c_start = 1'b0; c_mode = 2'b00; c_opa = '0; c_opb = '0; c_tag = '0;
    tick(); tick();
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_result", a_res, 0);
    chk("rst_tag", a_tago, 0);
    chk("rst_b_result", b_res, 0);
    arst_n = 1'b1;
    tick();

    // MUL 7 x -3, 64-bit, one bit per cycle
    a_go(2'b00, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd12);
    #1;
    chk("stall_on_start", a_stall, 1);
    a_wait(0, 0, lat);
    chk("mul_lat", lat, 65);
    chk("mul_stall_gap", a_stall_low, 0);
    chk("mul_result", a_res, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("mul_tag", a_tago, 12);
    tick();
    chk("done_one_cycle", a_done, 0);
    chk("idle_after_done", a_busy, 0);

    // 8-bit signedness corners
    b_op(2'b01, 8'h80, 8'h80, lat);
    chk("b_mulh_lat", lat, 9);
    chk("b_mulh_min", b_res, 8'h40);
    b_op(2'b11, 8'hFF, 8'hFF, lat);
    chk("b_mulhu", b_res, 8'hFE);
    b_op(2'b10, 8'hFF, 8'hFF, lat);
    chk("b_mulhsu", b_res, 8'hFF);
    b_op(2'b00, 8'hFF, 8'hFF, lat);
    chk("b_mul", b_res, 8'h01);
    b_op(2'b01, 8'h7F, 8'h80, lat);
    chk("b_mulh_mixed", b_res, 8'hC0);

    // 64-bit, four bits per cycle: early-out then full runs
    c_op(2'b11, 64'd0, 64'd5, 5'd3, lat);
    chk("c_zero_lat", lat, 1);
    chk("c_zero_res", c_res, 0);
    chk("c_zero_tag", c_tago, 3);
    tick();
    chk("c_zero_done_drop", c_done, 0);
    c_op(2'b11, 64'h1_0000_0000, 64'h1_0000_0000, 5'd4, lat);
    chk("c_mulhu_lat", lat, 17);
    chk("c_mulhu_res", c_res, 1);
    c_op(2'b00, 64'h1_0000_0001, 64'h1_0000_0001, 5'd5, lat);
    chk("c_mul_res", c_res, 64'h2_0000_0001);

    // Back-to-back with start held; operands change while busy
    a_go(2'b00, 64'd2, 64'd3, 5'd1);
    tick();
    repeat (4) tick();
    a_opa = 64'd5; a_opb = 64'd7; a_tag = 5'd2;
    a_wait(1, 5, lat);
    chk("b2b_first_lat", lat, 65);
    chk("b2b_first_res", a_res, 6);
    chk("b2b_first_tag", a_tago, 1);
    a_wait(0, 0, lat);
    chk("b2b_second_gap", lat, 65);
    chk("b2b_second_res", a_res, 35);
    chk("b2b_second_tag", a_tago, 2);
    tick();

    // Start pulse while busy is ignored
    a_go(2'b00, 64'd4, 64'd4, 5'd3);
    tick();
    a_start = 1'b0;
    repeat (4) tick();
    a_opa = 64'd9; a_opb = 64'd9; a_tag = 5'd4; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_wait(0, 6, lat);
    chk("pulse_lat", lat, 65);
    chk("pulse_res", a_res, 16);
    chk("pulse_tag", a_tago, 3);
    tick();
    chk("pulse_no_second_busy", a_busy, 0);
    chk("pulse_no_second_done", a_done, 0);

    // Flush mid-operation
    a_go(2'b00, 64'd100, 64'd100, 5'd6);
    tick();
    a_start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", a_busy, 0);
    n = 0;
    repeat (80) begin
      tick();
      if (a_done) n++;
    end
    chk("flush_no_done", n, 0);
    chk("flush_keeps_result", a_res, 16);

    // Flush together with start in IDLE does not accept
    a_go(2'b00, 64'd3, 64'd3, 5'd7);
    flush = 1'b1;
    tick();
    a_start = 1'b0;
    flush = 1'b0;
    chk("flush_start_busy", a_busy, 0);
    tick();
    chk("flush_start_done", a_done, 0);

    // Enable low for 20 cycles mid-operation
    a_go(2'b00, 64'd11, 64'd13, 5'd8);
    tick();
    a_start = 1'b0;
    repeat (9) tick();
    enable = 1'b0;
    repeat (20) tick();
    chk("enable_hold_busy", a_busy, 1);
    enable = 1'b1;
    a_wait(0, 30, lat);
    chk("enable_lat", lat, 85);
    chk("enable_res", a_res, 143);
    tick();

    // Reset mid-operation, then a normal operation
    a_go(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10);
    tick();
    a_start = 1'b0;
    repeat (9) tick();
    arst_n = 1'b0;
    tick();
    arst_n = 1'b1;
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_done", a_done, 0);
    chk("mid_rst_result", a_res, 0);
    chk("mid_rst_tag", a_tago, 0);
    a_go(2'b01, 64'h8000_0000_0000_0000, 64'd2, 5'd9);
    a_wait(0, 0, lat);
    chk("post_rst_lat", lat, 65);
    chk("post_rst_res", a_res, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("post_rst_tag", a_tago, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
